// File: rtl/color_centroid.sv
// color_centroid
//   Snoops the colour filter's write stream into the processed frame buffer and
//   accumulates the count and x/y coordinate sums of every non-black pixel of a
//   frame. At end of frame a sequential restoring divider computes the blob
//   centroid; results are held until the next frame finishes.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   proc_we, proc_addr, proc_pxl  snooped pixel write (row-major address, 0 = black)
//   centroid_x, centroid_y        blob centroid (0 when found = 0)
//   blob_cnt                      non-black pixel count of the last frame
//   found                         blob_cnt >= c_min_pxls
//   centroid_valid                one-cycle pulse when the outputs update
//   busy                          divider running
//   bbox_xmin/xmax/ymin/ymax      blob bounding box (0 unless built and found)
//
// Build option
//   COLOR_CENTROID_BBOX_EN        build the bounding-box tracker; otherwise bbox_* = 0
module color_centroid #(
    parameter int unsigned c_img_cols    = 80,
    parameter int unsigned c_img_rows    = 60,
    parameter int unsigned c_img_pxls    = c_img_cols * c_img_rows,
    parameter int unsigned c_nb_img_pxls = 13,
    parameter int unsigned c_nb_cols     = 7,
    parameter int unsigned c_nb_rows     = 6,
    parameter int unsigned c_nb_buf      = 12,
    parameter int unsigned c_nb_sum      = 19,
    parameter int unsigned c_min_pxls    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     proc_we,
    input  logic [c_nb_img_pxls-1:0] proc_addr,
    input  logic [c_nb_buf-1:0]      proc_pxl,
    output logic [c_nb_cols-1:0]     centroid_x,
    output logic [c_nb_rows-1:0]     centroid_y,
    output logic [c_nb_img_pxls-1:0] blob_cnt,
    output logic                     found,
    output logic                     centroid_valid,
    output logic                     busy,
    output logic [c_nb_cols-1:0]     bbox_xmin,
    output logic [c_nb_cols-1:0]     bbox_xmax,
    output logic [c_nb_rows-1:0]     bbox_ymin,
    output logic [c_nb_rows-1:0]     bbox_ymax
);
    localparam int unsigned c_nb_it  = $clog2(c_nb_sum);
    localparam int unsigned c_nb_rem = c_nb_sum + 1;
    localparam int unsigned c_nb_sh  = c_nb_sum + 2;

    typedef enum logic [1:0] {StIdle, StDivX, StDivY, StDone} state_e;
    state_e state_q, state_d;

    // Frame accumulation
    logic                     sync_q, sync_d;
    logic [c_nb_cols-1:0]     col_q, col_d, cur_col;
    logic [c_nb_rows-1:0]     row_q, row_d, cur_row;
    logic [c_nb_img_pxls-1:0] exp_addr_q, exp_addr_d;
    logic [c_nb_img_pxls-1:0] cnt_q, cnt_d;
    logic [c_nb_sum-1:0]      sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic                     pxl_nb, addr_zero, in_seq, accept, eof, start;

    // Divider
    logic [c_nb_img_pxls-1:0] div_q;
    logic [c_nb_sum-1:0]      work_q, work_nx, sum_y_snap_q;
    logic [c_nb_rem-1:0]      rem_q, rem_nx;
    logic [c_nb_sh-1:0]       rem_sh, div_ext;
    logic [c_nb_it-1:0]       it_q;
    logic [c_nb_cols-1:0]     qx_q;
    logic                     ge, last_it, fnd;

    always_comb begin
        pxl_nb    = |proc_pxl;
        addr_zero = (proc_addr == '0);
        in_seq    = sync_q && !addr_zero && (proc_addr == exp_addr_q);
        // Address 0 always (re)starts a frame, even mid-frame.
        accept    = proc_we && (addr_zero || in_seq);
        eof       = accept && (proc_addr == c_nb_img_pxls'(c_img_pxls - 1));
        start     = eof && (state_q == StIdle);
        cur_col   = addr_zero ? '0 : col_q;
        cur_row   = addr_zero ? '0 : row_q;
    end

    always_comb begin
        sync_d     = sync_q;
        col_d      = col_q;
        row_d      = row_q;
        exp_addr_d = exp_addr_q;
        cnt_d      = cnt_q;
        sum_x_d    = sum_x_q;
        sum_y_d    = sum_y_q;
        // Any write off the expected address drops sync until the next address 0.
        if (proc_we) begin
            sync_d = addr_zero || (in_seq && !eof);
        end
        if (accept) begin
            cnt_d   = addr_zero ? '0 : cnt_q;
            sum_x_d = addr_zero ? '0 : sum_x_q;
            sum_y_d = addr_zero ? '0 : sum_y_q;
            if (pxl_nb) begin
                cnt_d   = cnt_d + c_nb_img_pxls'(1);
                sum_x_d = sum_x_d + c_nb_sum'(cur_col);
                sum_y_d = sum_y_d + c_nb_sum'(cur_row);
            end
            exp_addr_d = proc_addr + c_nb_img_pxls'(1);
            if (cur_col == c_nb_cols'(c_img_cols - 1)) begin
                col_d = '0;
                row_d = cur_row + c_nb_rows'(1);
            end else begin
                col_d = cur_col + c_nb_cols'(1);
                row_d = cur_row;
            end
        end
    end

    // One restoring step per cycle: dividend bits enter from the top of work_q,
    // quotient bits fill in from the bottom.
    always_comb begin
        rem_sh  = {rem_q, work_q[c_nb_sum-1]};
        div_ext = c_nb_sh'(div_q);
        ge      = (rem_sh >= div_ext);
        rem_nx  = ge ? c_nb_rem'(rem_sh - div_ext) : c_nb_rem'(rem_sh);
        work_nx = {work_q[c_nb_sum-2:0], ge};
        last_it = (it_q == c_nb_it'(c_nb_sum - 1));
        // Gates every quotient use, so a zero divisor never reaches the outputs.
        fnd     = (div_q >= c_nb_img_pxls'(c_min_pxls));
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StDivX;
            StDivX:  if (last_it) state_d = StDivY;
            StDivY:  if (last_it) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q         <= 1'b0;
            col_q          <= '0;
            row_q          <= '0;
            exp_addr_q     <= '0;
            cnt_q          <= '0;
            sum_x_q        <= '0;
            sum_y_q        <= '0;
            div_q          <= '0;
            work_q         <= '0;
            sum_y_snap_q   <= '0;
            rem_q          <= '0;
            it_q           <= '0;
            qx_q           <= '0;
            centroid_x     <= '0;
            centroid_y     <= '0;
            blob_cnt       <= '0;
            found          <= 1'b0;
            centroid_valid <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            col_q          <= col_d;
            row_q          <= row_d;
            exp_addr_q     <= exp_addr_d;
            cnt_q          <= cnt_d;
            sum_x_q        <= sum_x_d;
            sum_y_q        <= sum_y_d;
            centroid_valid <= (state_q == StDone);
            unique case (state_q)
                StIdle: begin
                    // Snapshot includes the last pixel of the frame.
                    if (start) begin
                        div_q        <= cnt_d;
                        work_q       <= sum_x_d;
                        sum_y_snap_q <= sum_y_d;
                        rem_q        <= '0;
                        it_q         <= '0;
                    end
                end
                StDivX: begin
                    rem_q  <= rem_nx;
                    work_q <= work_nx;
                    it_q   <= it_q + c_nb_it'(1);
                    if (last_it) begin
                        qx_q   <= c_nb_cols'(work_nx);
                        work_q <= sum_y_snap_q;
                        rem_q  <= '0;
                        it_q   <= '0;
                    end
                end
                StDivY: begin
                    rem_q  <= rem_nx;
                    work_q <= work_nx;
                    it_q   <= it_q + c_nb_it'(1);
                end
                StDone: begin
                    blob_cnt   <= div_q;
                    found      <= fnd;
                    centroid_x <= fnd ? qx_q : '0;
                    centroid_y <= fnd ? c_nb_rows'(work_q) : '0;
                end
                default: ;
            endcase
        end
    end

`ifdef COLOR_CENTROID_BBOX_EN
    logic [c_nb_cols-1:0] xmin_q, xmin_d, xmax_q, xmax_d, sxmin_q, sxmax_q;
    logic [c_nb_rows-1:0] ymin_q, ymin_d, ymax_q, ymax_d, symin_q, symax_q;

    always_comb begin
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        if (accept) begin
            xmin_d = addr_zero ? c_nb_cols'(c_img_cols - 1) : xmin_q;
            xmax_d = addr_zero ? '0 : xmax_q;
            ymin_d = addr_zero ? c_nb_rows'(c_img_rows - 1) : ymin_q;
            ymax_d = addr_zero ? '0 : ymax_q;
            if (pxl_nb) begin
                if (cur_col < xmin_d) xmin_d = cur_col;
                if (cur_col > xmax_d) xmax_d = cur_col;
                if (cur_row < ymin_d) ymin_d = cur_row;
                if (cur_row > ymax_d) ymax_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xmin_q    <= '0;
            xmax_q    <= '0;
            ymin_q    <= '0;
            ymax_q    <= '0;
            sxmin_q   <= '0;
            sxmax_q   <= '0;
            symin_q   <= '0;
            symax_q   <= '0;
            bbox_xmin <= '0;
            bbox_xmax <= '0;
            bbox_ymin <= '0;
            bbox_ymax <= '0;
        end else begin
            xmin_q <= xmin_d;
            xmax_q <= xmax_d;
            ymin_q <= ymin_d;
            ymax_q <= ymax_d;
            if (start) begin
                sxmin_q <= xmin_d;
                sxmax_q <= xmax_d;
                symin_q <= ymin_d;
                symax_q <= ymax_d;
            end
            if (state_q == StDone) begin
                bbox_xmin <= fnd ? sxmin_q : '0;
                bbox_xmax <= fnd ? sxmax_q : '0;
                bbox_ymin <= fnd ? symin_q : '0;
                bbox_ymax <= fnd ? symax_q : '0;
            end
        end
    end
`else
    assign bbox_xmin = '0;
    assign bbox_xmax = '0;
    assign bbox_ymin = '0;
    assign bbox_ymax = '0;
`endif

endmodule

// File: tb/tb_color_centroid.sv
module tb_color_centroid;
    localparam int MinPxls = 1;
    localparam int Lat     = 39;
    localparam int Cols    = 80;
    localparam int Pxls    = 4800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        proc_we = 1'b0;
    logic [12:0] proc_addr = '0;
    logic [11:0] proc_pxl = '0;
    logic [6:0]  centroid_x, bbox_xmin, bbox_xmax;
    logic [5:0]  centroid_y, bbox_ymin, bbox_ymax;
    logic [12:0] blob_cnt;
    logic        found, centroid_valid, busy;

    color_centroid #(.c_min_pxls(MinPxls)) dut (
        .clk(clk), .rst(rst), .proc_we(proc_we), .proc_addr(proc_addr), .proc_pxl(proc_pxl),
        .centroid_x(centroid_x), .centroid_y(centroid_y), .blob_cnt(blob_cnt), .found(found),
        .centroid_valid(centroid_valid), .busy(busy), .bbox_xmin(bbox_xmin),
        .bbox_xmax(bbox_xmax), .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int tag; int cnt; int found; int x; int y;
        int xmin; int xmax; int ymin; int ymax; longint at;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    function automatic exp_t mk(int tag, longint k, int cnt, int fnd, int x, int y,
                                int xmin, int xmax, int ymin, int ymax);
        exp_t e;
        e.tag = tag; e.at = k + Lat; e.cnt = cnt; e.found = fnd; e.x = x; e.y = y;
`ifdef COLOR_CENTROID_BBOX_EN
        e.xmin = xmin; e.xmax = xmax; e.ymin = ymin; e.ymax = ymax;
`else
        e.xmin = 0; e.xmax = 0; e.ymin = 0; e.ymax = 0;
        if (xmin + xmax + ymin + ymax < 0) e.xmin = 0;
`endif
        return e;
    endfunction

    // Scoreboard: every valid pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && centroid_valid) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_valid at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                total++;
                if (cyc !== e.at) $display("FAIL latency tag=%0d got=%0d exp=%0d", e.tag, cyc, e.at);
                else passed++;
                total++;
                if (blob_cnt !== 13'(e.cnt))
                    $display("FAIL blob_cnt tag=%0d got=%0d exp=%0d", e.tag, blob_cnt, e.cnt);
                else passed++;
                total++;
                if (found !== 1'(e.found))
                    $display("FAIL found tag=%0d got=%0d exp=%0d", e.tag, found, e.found);
                else passed++;
                total++;
                if (centroid_x !== 7'(e.x))
                    $display("FAIL centroid_x tag=%0d got=%0d exp=%0d", e.tag, centroid_x, e.x);
                else passed++;
                total++;
                if (centroid_y !== 6'(e.y))
                    $display("FAIL centroid_y tag=%0d got=%0d exp=%0d", e.tag, centroid_y, e.y);
                else passed++;
                total++;
                if ({bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} !==
                    {7'(e.xmin), 7'(e.xmax), 6'(e.ymin), 6'(e.ymax)})
                    $display("FAIL bbox tag=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", e.tag,
                             bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax,
                             e.xmin, e.xmax, e.ymin, e.ymax);
                else passed++;
            end
        end
    end

    function automatic logic [11:0] pix(int kind, int col, int row);
        case (kind)
            1: return (row == 1 && col == 1) ? 12'h0F0 : 12'h000;
            2: return 12'hFFF;
            3: return (col >= 10 && col <= 19 && row >= 20 && row <= 29) ? 12'h00F : 12'h000;
            4: return ($urandom_range(0, 15) == 0) ? 12'($urandom_range(1, 4095)) : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    // Drives addresses first..Pxls-1 (skipping 'skip'); models count/sums/bbox.
    task automatic send_frame(input int kind, input int gaps, input int first, input int skip,
                              output longint k, output int cnt, output int sx, output int sy,
                              output int xmin, output int xmax, output int ymin, output int ymax);
        logic [11:0] p;
        int col, row;
        k = 0; cnt = 0; sx = 0; sy = 0; xmin = 79; xmax = 0; ymin = 59; ymax = 0;
        for (int a = first; a < Pxls; a++) begin
            if (a != skip) begin
                col = a % Cols;
                row = a / Cols;
                p = pix(kind, col, row);
                if (gaps != 0 && $urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    proc_we = 1'b0;
                end
                @(negedge clk);
                proc_we = 1'b1;
                proc_addr = 13'(a);
                proc_pxl = p;
                if (p != 12'h000) begin
                    cnt++; sx += col; sy += row;
                    if (col < xmin) xmin = col;
                    if (col > xmax) xmax = col;
                    if (row < ymin) ymin = row;
                    if (row > ymax) ymax = row;
                end
                if (a == Pxls - 1) k = cyc + 1;
            end
        end
        @(negedge clk);
        proc_we = 1'b0;
        proc_pxl = '0;
    endtask

    task automatic wait_results(input int tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            $display("FAIL result_timeout tag=%0d got=%0d pending exp=0", tag, sb.size());
            sb.delete();
        end
    endtask

    longint k, k2;
    int cnt, sx, sy, xmin, xmax, ymin, ymax;

    task automatic test_reset();
        rst = 1'b1;
        proc_we = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({centroid_valid, busy, found} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=000", {centroid_valid, busy, found});
        else passed++;
        total++;
        if ({centroid_x, centroid_y, blob_cnt} !== 26'd0)
            $display("FAIL reset_outputs got=%0d/%0d/%0d exp=0/0/0", centroid_x, centroid_y, blob_cnt);
        else passed++;
        total++;
        if ({bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} !== 26'd0)
            $display("FAIL reset_bbox got=%0d/%0d/%0d/%0d exp=0", bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_black();
        send_frame(0, 0, 0, -1, k, cnt, sx, sy, xmin, xmax, ymin, ymax);
        sb.push_back(mk(0, k, 0, 0, 0, 0, 0, 0, 0, 0));
        wait_results(0);
    endtask

    task automatic test_single();
        send_frame(1, 0, 0, -1, k, cnt, sx, sy, xmin, xmax, ymin, ymax);
        sb.push_back(mk(1, k, 1, 1, 1, 1, 1, 1, 1, 1));
        wait_results(1);
    endtask

    task automatic test_white();
        send_frame(2, 0, 0, -1, k, cnt, sx, sy, xmin, xmax, ymin, ymax);
        sb.push_back(mk(2, k, 4800, 1, 39, 29, 0, 79, 0, 59));
        wait_results(2);
    endtask

    task automatic test_square();
        send_frame(3, 0, 0, -1, k, cnt, sx, sy, xmin, xmax, ymin, ymax);
        sb.push_back(mk(3, k, 100, 1, 14, 24, 10, 19, 20, 29));
        @(negedge clk);
        total++;
        if (busy !== 1'b1) $display("FAIL busy_during_div got=%b exp=1", busy);
        else passed++;
        wait_results(3);
        repeat (20) @(negedge clk);
        total++;
        if ({centroid_valid, busy} !== 2'b00)
            $display("FAIL idle_after_done got=%b exp=00", {centroid_valid, busy});
        else passed++;
        total++;
        if (centroid_x !== 7'd14 || centroid_y !== 6'd24 || blob_cnt !== 13'd100 || found !== 1'b1)
            $display("FAIL hold_outputs got=%0d/%0d/%0d/%0d exp=14/24/100/1",
                     centroid_x, centroid_y, blob_cnt, found);
        else passed++;
    endtask

    task automatic test_random_gaps();
        int f;
        send_frame(4, 1, 0, -1, k, cnt, sx, sy, xmin, xmax, ymin, ymax);
        f = (cnt >= MinPxls) ? 1 : 0;
        if (f != 0) sb.push_back(mk(4, k, cnt, 1, sx / cnt, sy / cnt, xmin, xmax, ymin, ymax));
        else sb.push_back(mk(4, k, cnt, 0, 0, 0, 0, 0, 0, 0));
        wait_results(4);
    endtask

    task automatic test_addr_skip();
        // Frame without a leading address 0, then a frame with 4 -> 6: neither may report.
        send_frame(3, 0, 1, -1, k, cnt, sx, sy, xmin, xmax, ymin, ymax);
        send_frame(3, 0, 0, 5, k, cnt, sx, sy, xmin, xmax, ymin, ymax);
        repeat (60) @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL skip_no_divide got=%b exp=0", busy);
        else passed++;
        send_frame(1, 0, 0, -1, k, cnt, sx, sy, xmin, xmax, ymin, ymax);
        sb.push_back(mk(5, k, 1, 1, 1, 1, 1, 1, 1, 1));
        wait_results(5);
    endtask

    task automatic test_back_to_back();
        send_frame(2, 0, 0, -1, k, cnt, sx, sy, xmin, xmax, ymin, ymax);
        sb.push_back(mk(6, k, 4800, 1, 39, 29, 0, 79, 0, 59));
        send_frame(3, 0, 0, -1, k2, cnt, sx, sy, xmin, xmax, ymin, ymax);
        sb.push_back(mk(7, k2, 100, 1, 14, 24, 10, 19, 20, 29));
        wait_results(7);
    endtask

    task automatic test_reset_mid_div();
        send_frame(2, 0, 0, -1, k, cnt, sx, sy, xmin, xmax, ymin, ymax);
        while (cyc < k + 10) @(negedge clk);
        total++;
        if (busy !== 1'b1) $display("FAIL busy_before_rst got=%b exp=1", busy);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, centroid_valid, found} !== 3'b000)
            $display("FAIL rst_mid_div_flags got=%b exp=000", {busy, centroid_valid, found});
        else passed++;
        total++;
        if ({centroid_x, centroid_y, blob_cnt, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} !== 52'd0)
            $display("FAIL rst_mid_div_outputs got=%0d/%0d/%0d exp=0/0/0", centroid_x, centroid_y, blob_cnt);
        else passed++;
        rst = 1'b0;
        repeat (60) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_black();
        test_single();
        test_white();
        test_square();
        test_random_gaps();
        test_addr_skip();
        test_back_to_back();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=%0d cycles exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
